// File: rtl/prog_sequencer.sv
// Batch sequencer: runs NUM_PROGS programs back to back on the instruction fetch unit,
// counting RUN cycles per program and aborting the batch if a program exceeds TIMEOUT.
module prog_sequencer #(
    parameter int NUM_PROGS = 3,
    parameter int CYC_W     = 16,
    parameter int TIMEOUT   = 16'hFFFF,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             stall,
    output logic             init,
    output logic             fetch_unit_en,
    output logic [7:0]       start_address,
    output logic [1:0]       prog_id,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CYC_W-1:0] cycle_count,
    output logic [CYC_W-1:0] last_cycles
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT - 1);
    localparam logic [3:0]       DRAIN_LOAD   = 4'(DRAIN_CYC - 1);
    localparam logic [1:0]       LAST_PROG    = 2'(NUM_PROGS);

    state_t           state_reg;
    logic [3:0]       drain_cnt_reg;
    logic [1:0]       prog_id_reg;
    logic [CYC_W-1:0] cycle_count_reg;
    logic [CYC_W-1:0] last_cycles_reg;
    logic             init_reg;
    logic             done_reg;
    logic             timeout_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            drain_cnt_reg   <= '0;
            prog_id_reg     <= '0;
            cycle_count_reg <= '0;
            last_cycles_reg <= '0;
            init_reg        <= 1'b0;
            done_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            // init and done are single-cycle pulses, raised on entry to INIT/DONE
            init_reg <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg       <= S_INIT;
                        init_reg        <= 1'b1;
                        prog_id_reg     <= 2'd1;
                        cycle_count_reg <= '0;
                        timeout_reg     <= 1'b0;
                    end
                end
                S_INIT: state_reg <= S_RUN;
                S_RUN: begin
                    cycle_count_reg <= cycle_count_reg + CYC_W'(1);
                    // halt takes priority over a coincident timeout
                    if (halt) begin
                        last_cycles_reg <= cycle_count_reg + CYC_W'(1);
                        drain_cnt_reg   <= DRAIN_LOAD;
                        state_reg       <= S_DRAIN;
                    end else if (cycle_count_reg == TIMEOUT_LAST) begin
                        timeout_reg <= 1'b1;
                        done_reg    <= 1'b1;
                        state_reg   <= S_DONE;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_reg == 4'd0) begin
                        if (prog_id_reg == LAST_PROG) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_NEXT;
                        end
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - 4'd1;
                    end
                end
                S_NEXT: begin
                    prog_id_reg     <= prog_id_reg + 2'd1;
                    cycle_count_reg <= '0;
                    init_reg        <= 1'b1;
                    state_reg       <= S_INIT;
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Fetch follows stall combinationally so a hazard freezes the PC in the same cycle
    assign fetch_unit_en = (state_reg == S_RUN) && !stall;
    assign busy          = (state_reg != S_IDLE);
    assign init          = init_reg;
    assign done          = done_reg;
    assign timeout       = timeout_reg;
    assign prog_id       = prog_id_reg;
    assign cycle_count   = cycle_count_reg;
    assign last_cycles   = last_cycles_reg;
    assign start_address = 8'h00;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: table of batch scenarios plus a mid-batch reset
// sequence; init/done pulses are checked against a scoreboard of expected events.
module tb_prog_sequencer;

    localparam int TO    = 20;
    localparam int NPROG = 3;

    logic        clk = 1'b0;
    logic        reset, start, halt, stall;
    logic        init, fetch_unit_en, busy, done, timeout;
    logic [7:0]  start_address;
    logic [1:0]  prog_id;
    logic [15:0] cycle_count, last_cycles;

    prog_sequencer #(
        .NUM_PROGS(NPROG),
        .CYC_W(16),
        .TIMEOUT(TO),
        .DRAIN_CYC(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .halt(halt),
        .stall(stall),
        .init(init),
        .fetch_unit_en(fetch_unit_en),
        .start_address(start_address),
        .prog_id(prog_id),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .cycle_count(cycle_count),
        .last_cycles(last_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int prog;
        bit to;
        int last;
    } ev_t;

    typedef struct {
        int run_len;      // halt on this RUN cycle; 0 = never halt
        int stall_at;
        int stall_len;
        bit noise;        // start during RUN, halt during DRAIN
        bit exp_timeout;
    } vec_t;

    ev_t  sb[$];
    ev_t  mon_ev;
    vec_t vecs[6];
    int   tests = 0;
    int   fails = 0;
    int   exp_last = 0;
    int   inits_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string msg);
        tests++;
        fails++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Scoreboard monitor: every init/done pulse must match the next expected event
    always @(negedge clk) begin
        if (!reset) begin
            if (init) begin
                inits_seen++;
                check("init_vs_fetch", fetch_unit_en, 0);
                if (sb.size() == 0) flag("unexpected_init", "got init pulse, expected none");
                else begin
                    mon_ev = sb.pop_front();
                    if (mon_ev.is_done) flag("event_order", "got init, expected done");
                    else check("init_prog_id", prog_id, mon_ev.prog);
                    $display("[TB] init prog_id=%0d", prog_id);
                end
            end
            if (done) begin
                if (sb.size() == 0) flag("unexpected_done", "got done pulse, expected none");
                else begin
                    mon_ev = sb.pop_front();
                    if (!mon_ev.is_done) flag("event_order", "got done, expected init");
                    else begin
                        check("done_prog_id", prog_id, mon_ev.prog);
                        check("done_timeout", timeout, mon_ev.to);
                        check("done_last_cycles", last_cycles, mon_ev.last);
                    end
                    $display("[TB] done prog_id=%0d timeout=%0d last_cycles=%0d",
                             prog_id, timeout, last_cycles);
                end
            end
        end
    end

    task automatic run_batch(input vec_t v);
        bit timed_out;
        inits_seen = 0;
        @(negedge clk);
        start = 1'b1;
        sb.push_back('{is_done: 1'b0, prog: 1, to: 1'b0, last: 0});
        @(negedge clk);           // INIT
        start = 1'b0;
        for (int p = 1; p <= NPROG; p++) begin
            timed_out = 1'b0;
            for (int i = 1; i <= TO; i++) begin
                @(negedge clk);   // RUN cycle i
                stall = (i >= v.stall_at) && (i < v.stall_at + v.stall_len);
                start = v.noise;
                halt  = (i == v.run_len);
                if (!halt && i == TO) begin
                    timed_out = 1'b1;
                    sb.push_back('{is_done: 1'b1, prog: p, to: 1'b1, last: exp_last});
                end
                #1;
                check("fetch_en", fetch_unit_en, !stall);
                check("cycle_count", cycle_count, i - 1);
                if (halt || timed_out) break;
            end
            @(negedge clk);       // DRAIN1, or DONE after a timeout
            stall = 1'b0;
            start = 1'b0;
            halt  = v.noise;
            if (timed_out) begin
                @(negedge clk);   // IDLE
                halt = 1'b0;
                check("idle_busy", busy, 0);
                check("timeout_prog_id", prog_id, p);
                break;
            end
            exp_last = v.run_len;
            @(negedge clk);       // DRAIN2
            check("drain_fetch", fetch_unit_en, 0);
            check("drain_busy", busy, 1);
            check("drain_cycle_count", cycle_count, v.run_len);
            if (p < NPROG) begin
                sb.push_back('{is_done: 1'b0, prog: p + 1, to: 1'b0, last: 0});
                @(negedge clk);   // NEXT
                halt = 1'b0;
                check("next_fetch", fetch_unit_en, 0);
                @(negedge clk);   // INIT
            end else begin
                sb.push_back('{is_done: 1'b1, prog: NPROG, to: 1'b0, last: exp_last});
                @(negedge clk);   // DONE
                halt = 1'b0;
                @(negedge clk);   // IDLE
                check("idle_busy", busy, 0);
                check("idle_last_cycles", last_cycles, exp_last);
                check("idle_prog_id", prog_id, NPROG);
            end
        end
        check("timeout_flag", timeout, v.exp_timeout);
        check("init_count", inits_seen, v.exp_timeout ? 1 : NPROG);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{run_len: 10, stall_at: 0, stall_len: 0, noise: 1'b0, exp_timeout: 1'b0};
        vecs[1] = '{run_len: 12, stall_at: 3, stall_len: 4, noise: 1'b0, exp_timeout: 1'b0};
        vecs[2] = '{run_len: 0,  stall_at: 5, stall_len: 2, noise: 1'b0, exp_timeout: 1'b1};
        vecs[3] = '{run_len: TO, stall_at: 0, stall_len: 0, noise: 1'b0, exp_timeout: 1'b0};
        vecs[4] = '{run_len: 6,  stall_at: 2, stall_len: 1, noise: 1'b1, exp_timeout: 1'b0};
        vecs[5] = '{run_len: 1,  stall_at: 0, stall_len: 0, noise: 1'b0, exp_timeout: 1'b0};

        reset = 1'b1;
        start = 1'b0;
        halt  = 1'b0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_prog_id", prog_id, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_last_cycles", last_cycles, 0);
        check("rst_timeout", timeout, 0);
        check("rst_init", init, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("start_address", start_address, 8'h00);

        for (int r = 0; r < 6; r++) begin
            $display("[TB] vector %0d run_len=%0d stall=%0d+%0d noise=%0d", r,
                     vecs[r].run_len, vecs[r].stall_at, vecs[r].stall_len, vecs[r].noise);
            run_batch(vecs[r]);
        end

        // Reset in the middle of program 2's RUN phase
        @(negedge clk);
        start = 1'b1;
        sb.push_back('{is_done: 1'b0, prog: 1, to: 1'b0, last: 0});
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            halt = (i == 5);
        end
        @(negedge clk);           // DRAIN1
        halt = 1'b0;
        @(negedge clk);           // DRAIN2
        sb.push_back('{is_done: 1'b0, prog: 2, to: 1'b0, last: 0});
        repeat (4) @(negedge clk); // NEXT, INIT, RUN1, RUN2
        check("pre_rst_prog_id", prog_id, 2);
        check("pre_rst_sb_empty", sb.size(), 0);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_prog_id", prog_id, 0);
        check("midrst_cycle_count", cycle_count, 0);
        check("midrst_last_cycles", last_cycles, 0);
        check("midrst_fetch", fetch_unit_en, 0);
        check("midrst_init", init, 0);
        check("midrst_done", done, 0);
        check("midrst_timeout", timeout, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_last = 0;
        repeat (3) @(negedge clk);
        check("after_rst_busy", busy, 0);
        $display("[TB] restart after mid-batch reset");
        run_batch(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter NUM_PROGS, default 3: number of programs run per batch; legal range 1..3.
REQ-002 Parameter CYC_W, default 16: width of the cycle counters.
REQ-003 Parameter TIMEOUT, default 16'hFFFF: RUN-cycle limit per program before abort; value is less than 2^CYC_W.
REQ-004 Parameter DRAIN_CYC, default 2: idle cycles after halt before the next program starts; legal range 1..15.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  batch request, sampled in IDLE only.
REQ-008 halt  input  1  datapath reports the current program has finished.
REQ-009 stall  input  1  datapath hazard; holds fetch during RUN.
REQ-010 init  output  1  one-cycle pulse that loads the instruction-memory PC and advances its program select.
REQ-011 fetch_unit_en  output  1  fetch/PC-advance enable to the instruction memory.
REQ-012 start_address  output  8  PC load value; constant 8'h00.
REQ-013 prog_id  output  2  index of the current program, 1..NUM_PROGS; 0 when no program has started.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at batch end.
REQ-016 timeout  output  1  sticky abort flag for the last batch.
REQ-017 cycle_count  output  CYC_W  RUN cycles counted for the current program.
REQ-018 last_cycles  output  CYC_W  cycle_count of the most recently completed program.

Function
REQ-019 The FSM SHALL have states IDLE, INIT, RUN, DRAIN, NEXT, DONE, encoded in 3 bits.
REQ-020 IDLE, start=1 SHALL transition to INIT and set prog_id<=1, cycle_count<=0, timeout<=0.
REQ-021 IDLE, start=0 SHALL remain in IDLE; start in any other state SHALL be ignored.
REQ-022 INIT SHALL assert init=1 and fetch_unit_en=0 for exactly one cycle, then transition to RUN.
REQ-023 RUN SHALL drive fetch_unit_en = ~stall combinationally.
REQ-024 RUN SHALL increment cycle_count by 1 on every cycle, including stalled cycles.
REQ-025 RUN with halt=1 SHALL transition to DRAIN and latch last_cycles<=cycle_count+1.
REQ-026 RUN with halt=0 and cycle_count==TIMEOUT-1 SHALL set timeout<=1 and go directly to DONE, without draining.
REQ-027 When halt and the timeout condition coincide, halt SHALL win: no timeout is flagged and the FSM enters DRAIN.
REQ-028 DRAIN SHALL hold fetch_unit_en=0 for DRAIN_CYC cycles using a 4-bit down-counter.
REQ-029 At the end of DRAIN, the FSM SHALL go to DONE if prog_id==NUM_PROGS, else to NEXT.
REQ-030 NEXT SHALL last one cycle with fetch_unit_en=0, set prog_id<=prog_id+1 and cycle_count<=0, then go to INIT.
REQ-031 DONE SHALL assert done=1 for one cycle and return to IDLE.
REQ-032 IDLE SHALL keep prog_id, last_cycles and timeout holding their values.
REQ-033 halt SHALL be ignored outside RUN.
REQ-034 init and fetch_unit_en SHALL never be high in the same cycle.
REQ-035 init, done and fetch_unit_en SHALL be 0 in IDLE, DRAIN, NEXT and DONE, except done in DONE.
REQ-036 cycle_count SHALL NOT wrap, because the TIMEOUT bound stops RUN first.

Reset
REQ-037 Asserting reset SHALL immediately force state=IDLE, init=0, fetch_unit_en=0, done=0, busy=0, prog_id=0, timeout=0, cycle_count=0, last_cycles=0 and the drain counter to 0.
REQ-038 Reset asserted mid-batch SHALL abort the batch with no done pulse.
REQ-039 The first cycle after reset deasserts SHALL be IDLE.

Verification
REQ-040 Full batch: start pulse, halt after 10 RUN cycles each program, NUM_PROGS=3 -> three init pulses with prog_id 1,2,3; last_cycles=10 after each; one done pulse; busy falls the following cycle.
REQ-041 Stall: 4 stall cycles inside RUN -> fetch_unit_en=0 for exactly those 4 cycles; cycle_count includes them; last_cycles = total RUN cycles.
REQ-042 Timeout: TIMEOUT=20, halt never asserted -> timeout=1 after 20 RUN cycles; done pulses; no DRAIN; prog_id stays 1.
REQ-043 Halt/timeout coincident: halt on cycle TIMEOUT -> timeout=0 and DRAIN is entered.
REQ-044 Reset mid-RUN of program 2 -> all outputs at reset values within the same cycle; no done; start then restarts at prog_id=1.
REQ-045 Ignored inputs: start during RUN and halt during DRAIN -> no state or counter change; init pulse count per batch equals NUM_PROGS.
